// File: rtl/bubble_level_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bubble_level_pkg                                               |
// | Purpose : Shared types and constants for the bubble-level demo: master   |
// |           FSM state encoding, default I2C addressing and LED bar size.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package bubble_level_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR_SETUP  = 4'd1,
    WR_STROBE = 4'd2,
    WR_BUSY   = 4'd3,
    WR_DONE   = 4'd4,
    WR_CHECK  = 4'd5,
    RD_SETUP  = 4'd6,
    RD_STROBE = 4'd7,
    RD_BUSY   = 4'd8,
    RD_VALID  = 4'd9,
    RD_CHECK  = 4'd10,
    RD_DELAY  = 4'd11,
    ERROR     = 4'd12
  } state_t;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR7 = 7'h68;
  localparam logic [7:0] DEFAULT_WAKE_REG    = 8'h6B;
  localparam logic [7:0] DEFAULT_AXIS_REG    = 8'h3D;

  // Every transfer is command byte + one data byte.
  localparam logic [7:0] XFER_NUM_BYTES = 8'd2;

  localparam int NUM_LEDS   = 9;
  localparam int LED_CENTER = 4;

endpackage
`default_nettype wire

// File: rtl/bubble_level_fsm_level_led_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : level_led_decoder                                              |
// | Purpose : Maps a signed 8-bit tilt sample to a one-hot LED bar.          |
// |           q = s/2 (toward zero), idx = clamp(LED_CENTER - q, 0, N-1).    |
// | Ports   : data_i [7:0]          signed tilt sample                       |
// |           led_o  [NUM_LEDS-1:0] one-hot bar, bit LED_CENTER = level      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module level_led_decoder
  import bubble_level_pkg::*;
(
  input  logic [7:0]          data_i,
  output logic [NUM_LEDS-1:0] led_o
);

  logic signed [7:0] w_s;
  logic signed [7:0] w_q;
  logic        [8:0] w_diff;
  logic        [3:0] w_idx;

  always_comb begin
    w_s    = $signed(data_i);
    // SV signed division truncates toward zero, which is the intended rounding.
    w_q    = w_s / 8'sd2;
    // 9-bit difference cannot overflow: range is 4-63 .. 4+64.
    w_diff = 9'(LED_CENTER) - {w_q[7], w_q};
    if ($signed(w_diff) < 0)
      w_idx = 4'd0;
    else if ($signed(w_diff) > (NUM_LEDS - 1))
      w_idx = 4'(NUM_LEDS - 1);
    else
      w_idx = w_diff[3:0];
    led_o = NUM_LEDS'(1) << w_idx;
  end

endmodule
`default_nettype wire

// File: rtl/bubble_level_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bubble_level_fsm                                               |
// | Purpose : Master FSM for the bubble-level demo. Wakes the accelerometer  |
// |           through a byte-oriented I2C master core, then loops reading    |
// |           one tilt axis register and shows it on a one-hot LED bar.      |
// |           Any bus failure latches error_led_o until reset.               |
// | Ports   : clk_i, reset_ni (async, active low)                            |
// |           i2c_* inputs : status from the I2C core (busy, ack, arb, done, |
// |                          read valid, read data)                          |
// |           i2c_* outputs: write/read strobes, address, data, command,     |
// |                          byte count                                      |
// |           error_led_o, led_o[8:0]                                        |
// | Config  : LEVEL_FSM_SAMPLE_DELAY_EN - when defined, waits DELAY_CYCLES   |
// |           in RD_DELAY between samples.                                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module bubble_level_fsm
  import bubble_level_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR7 = DEFAULT_SLAVE_ADDR7,
  parameter logic [7:0] WAKE_REG    = DEFAULT_WAKE_REG,
  parameter logic [7:0] AXIS_REG    = DEFAULT_AXIS_REG
`ifdef LEVEL_FSM_SAMPLE_DELAY_EN
  , parameter int       DELAY_CYCLES = 16
`endif
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                i2c_busy_i,
  input  logic                i2c_rxak_i,
  input  logic                i2c_arb_lost_i,
  input  logic                i2c_write_done_i,
  input  logic                i2c_data_out_valid_i,
  input  logic [7:0]          i2c_data_out_i,
  output logic                i2c_write_o,
  output logic                i2c_read_o,
  output logic [7:0]          i2c_slave_addr_o,
  output logic [7:0]          i2c_din_o,
  output logic [7:0]          i2c_command_byte_o,
  output logic [7:0]          i2c_num_bytes_o,
  output logic                error_led_o,
  output logic [NUM_LEDS-1:0] led_o
);

  state_t              r_state;
  logic                r_write;
  logic                r_read;
  logic [7:0]          r_addr;
  logic [7:0]          r_din;
  logic [7:0]          r_cmd;
  logic [7:0]          r_nbytes;
  logic                r_err_led;
  logic [NUM_LEDS-1:0] r_led;
  logic                r_seen_busy;  // busy observed high during this transfer
  logic                r_bus_err;    // error flags captured with done/valid
  logic [7:0]          r_data;       // sample captured with valid
  logic [NUM_LEDS-1:0] w_led;

`ifdef LEVEL_FSM_SAMPLE_DELAY_EN
  localparam int CNT_W = $clog2(DELAY_CYCLES + 1);
  logic [CNT_W-1:0]    r_cnt;
`endif

  level_led_decoder u_decoder (
    .data_i (r_data),
    .led_o  (w_led)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state     <= IDLE;
      r_write     <= 1'b0;
      r_read      <= 1'b0;
      r_addr      <= 8'h00;
      r_din       <= 8'h00;
      r_cmd       <= 8'h00;
      r_nbytes    <= 8'h00;
      r_err_led   <= 1'b0;
      r_led       <= '0;
      r_seen_busy <= 1'b0;
      r_bus_err   <= 1'b0;
      r_data      <= 8'h00;
`ifdef LEVEL_FSM_SAMPLE_DELAY_EN
      r_cnt       <= '0;
`endif
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      r_write <= 1'b0;
      r_read  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!i2c_busy_i) begin
            r_addr   <= {SLAVE_ADDR7, 1'b0};
            r_cmd    <= WAKE_REG;
            r_din    <= 8'h00;
            r_nbytes <= XFER_NUM_BYTES;
            r_state  <= WR_SETUP;
          end
        end
        WR_SETUP: begin
          r_write <= 1'b1;
          r_state <= WR_STROBE;
        end
        WR_STROBE: begin
          r_seen_busy <= 1'b0;
          r_state     <= WR_BUSY;
        end
        // A done seen while still waiting on busy covers a core whose busy
        // pulse is too short to observe; errors are captured alongside.
        WR_BUSY: begin
          if (i2c_write_done_i) begin
            r_bus_err <= i2c_arb_lost_i | i2c_rxak_i;
            r_state   <= WR_CHECK;
          end else begin
            if (i2c_busy_i)
              r_seen_busy <= 1'b1;
            if (r_seen_busy && !i2c_busy_i)
              r_state <= WR_DONE;
          end
        end
        WR_DONE: begin
          if (i2c_write_done_i) begin
            r_bus_err <= i2c_arb_lost_i | i2c_rxak_i;
            r_state   <= WR_CHECK;
          end
        end
        WR_CHECK: begin
          if (r_bus_err || i2c_arb_lost_i || i2c_rxak_i) begin
            r_err_led <= 1'b1;
            r_state   <= ERROR;
          end else begin
            r_state <= RD_SETUP;
          end
        end
        RD_SETUP: begin
          if (!i2c_busy_i) begin
            r_addr   <= {SLAVE_ADDR7, 1'b0};
            r_cmd    <= AXIS_REG;
            r_nbytes <= XFER_NUM_BYTES;
            r_state  <= RD_STROBE;
          end
        end
        RD_STROBE: begin
          r_read      <= 1'b1;
          r_seen_busy <= 1'b0;
          r_state     <= RD_BUSY;
        end
        // rxak is not an error on reads: the master NACKs the final byte.
        RD_BUSY: begin
          if (i2c_data_out_valid_i) begin
            r_bus_err <= i2c_arb_lost_i;
            r_data    <= i2c_data_out_i;
            r_state   <= RD_CHECK;
          end else begin
            if (i2c_busy_i)
              r_seen_busy <= 1'b1;
            if (r_seen_busy && !i2c_busy_i)
              r_state <= RD_VALID;
          end
        end
        RD_VALID: begin
          if (i2c_data_out_valid_i) begin
            r_bus_err <= i2c_arb_lost_i;
            r_data    <= i2c_data_out_i;
            r_state   <= RD_CHECK;
          end
        end
        RD_CHECK: begin
          if (r_bus_err || i2c_arb_lost_i) begin
            r_err_led <= 1'b1;
            r_state   <= ERROR;
          end else begin
            r_led <= w_led;
`ifdef LEVEL_FSM_SAMPLE_DELAY_EN
            r_cnt   <= CNT_W'(DELAY_CYCLES - 1);
            r_state <= RD_DELAY;
`else
            r_state <= RD_SETUP;
`endif
          end
        end
`ifdef LEVEL_FSM_SAMPLE_DELAY_EN
        RD_DELAY: begin
          if (r_cnt == '0)
            r_state <= RD_SETUP;
          else
            r_cnt <= r_cnt - 1'b1;
        end
`endif
        ERROR: begin
          r_state <= ERROR;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign i2c_write_o        = r_write;
  assign i2c_read_o         = r_read;
  assign i2c_slave_addr_o   = r_addr;
  assign i2c_din_o          = r_din;
  assign i2c_command_byte_o = r_cmd;
  assign i2c_num_bytes_o    = r_nbytes;
  assign error_led_o        = r_err_led;
  assign led_o              = r_led;

endmodule
`default_nettype wire

// File: tb/tb_bubble_level_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_bubble_level_fsm                                            |
// | Purpose : Self-checking bench for bubble_level_fsm. The bench plays the  |
// |           I2C core: it answers strobes with busy/done/valid sequences    |
// |           and compares outputs against hand-computed values.             |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_bubble_level_fsm;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic       rxak;
  logic       arb;
  logic       wdone;
  logic       valid;
  logic [7:0] rdata;
  logic       write_o;
  logic       read_o;
  logic [7:0] addr_o;
  logic [7:0] din_o;
  logic [7:0] cmd_o;
  logic [7:0] nbytes_o;
  logic       err_o;
  logic [8:0] led_o;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] data;
    logic [8:0] exp_led;
  } vec_t;

  vec_t vecs[12];

  bubble_level_fsm dut (
    .clk_i                (clk),
    .reset_ni             (rst_n),
    .i2c_busy_i           (busy),
    .i2c_rxak_i           (rxak),
    .i2c_arb_lost_i       (arb),
    .i2c_write_done_i     (wdone),
    .i2c_data_out_valid_i (valid),
    .i2c_data_out_i       (rdata),
    .i2c_write_o          (write_o),
    .i2c_read_o           (read_o),
    .i2c_slave_addr_o     (addr_o),
    .i2c_din_o            (din_o),
    .i2c_command_byte_o   (cmd_o),
    .i2c_num_bytes_o      (nbytes_o),
    .error_led_o          (err_o),
    .led_o                (led_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Poll for a write or read strobe; returns sitting on the negedge where it is high.
  task automatic wait_strobe(input bit rd, input string nm);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (rd ? read_o : write_o) got = 1'b1;
    end
    chk(nm, {31'd0, got}, 32'd1);
  endtask

  // Act as the I2C core for one transfer, starting on the strobe negedge.
  // Done/valid is a one-cycle pulse carrying the given status flags.
  task automatic finish_xfer(input bit rd, input logic [7:0] d, input bit a, input bit r);
    busy = 1'b1;
    tick(1);
    chk(rd ? "read_o one cycle" : "write_o one cycle", {31'd0, rd ? read_o : write_o}, 32'd0);
    tick(1);
    busy  = 1'b0;
    rdata = d;
    arb   = a;
    rxak  = r;
    if (rd) valid = 1'b1;
    else    wdone = 1'b1;
    tick(1);
    valid = 1'b0;
    wdone = 1'b0;
    arb   = 1'b0;
    rxak  = 1'b0;
  endtask

  task automatic do_reset(input bit b);
    rst_n = 1'b0;
    busy  = b;
    rxak  = 1'b0;
    arb   = 1'b0;
    wdone = 1'b0;
    valid = 1'b0;
    rdata = 8'h00;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic count_strobes(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (write_o || read_o) cnt++;
    end
  endtask

  initial begin
    logic [8:0] last_led;
    int         ns;

    vecs[0]  = '{8'h00, 9'd16};   // level
    vecs[1]  = '{8'h10, 9'd1};    // +16 clamps to bit0
    vecs[2]  = '{8'h80, 9'd256};  // -128 clamps to bit8
    vecs[3]  = '{8'h7F, 9'd1};    // +127
    vecs[4]  = '{8'hF9, 9'd128};  // -7 -> q=-3 -> bit7
    vecs[5]  = '{8'h01, 9'd16};   // +1 truncates to q=0
    vecs[6]  = '{8'hFF, 9'd16};   // -1 truncates to q=0
    vecs[7]  = '{8'h03, 9'd8};    // q=1 -> bit3
    vecs[8]  = '{8'hFD, 9'd32};   // q=-1 -> bit5
    vecs[9]  = '{8'h08, 9'd1};    // q=4 -> exactly bit0
    vecs[10] = '{8'hF8, 9'd256};  // q=-4 -> exactly bit8
    vecs[11] = '{8'h06, 9'd2};    // q=3 -> bit1

    // Reset held with busy high: everything stays zero.
    do_reset(1'b1);
    tick(3);
    chk("reset write_o", {31'd0, write_o}, 32'd0);
    chk("reset read_o", {31'd0, read_o}, 32'd0);
    chk("reset addr", {24'd0, addr_o}, 32'h0);
    chk("reset cmd", {24'd0, cmd_o}, 32'h0);
    chk("reset nbytes", {24'd0, nbytes_o}, 32'h0);
    chk("reset err", {31'd0, err_o}, 32'd0);
    chk("reset led", {23'd0, led_o}, 32'd0);

    // Drop busy: setup next cycle, write strobe the cycle after.
    busy = 1'b0;
    tick(1);
    chk("wr setup cmd", {24'd0, cmd_o}, 32'h6B);
    chk("wr setup addr", {24'd0, addr_o}, 32'hD0);
    chk("wr setup din", {24'd0, din_o}, 32'h00);
    chk("wr setup nbytes", {24'd0, nbytes_o}, 32'd2);
    chk("wr setup no strobe", {31'd0, write_o}, 32'd0);
    tick(1);
    chk("write strobe", {31'd0, write_o}, 32'd1);

    // Clean write, then the first read strobe with the axis register.
    finish_xfer(1'b0, 8'h00, 1'b0, 1'b0);
    wait_strobe(1'b1, "first read strobe");
    chk("rd cmd", {24'd0, cmd_o}, 32'h3D);
    chk("rd addr", {24'd0, addr_o}, 32'hD0);
    chk("rd nbytes", {24'd0, nbytes_o}, 32'd2);
    chk("err after write", {31'd0, err_o}, 32'd0);

    // Read with rxak=1 (NACK on last byte) is not an error.
    finish_xfer(1'b1, 8'hF9, 1'b0, 1'b1);
    tick(1);
    chk("led 0xF9", {23'd0, led_o}, 32'd128);
    chk("err after nack read", {31'd0, err_o}, 32'd0);
    wait_strobe(1'b1, "read strobe again");

    // LED map table.
    foreach (vecs[i]) begin
      finish_xfer(1'b1, vecs[i].data, 1'b0, 1'b0);
      tick(1);
      chk($sformatf("led map 0x%02h", vecs[i].data), {23'd0, led_o}, {23'd0, vecs[i].exp_led});
      wait_strobe(1'b1, "read strobe loop");
    end
    last_led = vecs[11].exp_led;

    // Read error: valid together with arb_lost -> error wins, led holds.
    finish_xfer(1'b1, 8'h00, 1'b1, 1'b0);
    tick(1);
    chk("rd err led", {31'd0, err_o}, 32'd1);
    chk("rd err led hold", {23'd0, led_o}, {23'd0, last_led});
    count_strobes(30, ns);
    chk("no strobes in error", ns, 32'd0);
    chk("rd err sticky", {31'd0, err_o}, 32'd1);

    // Reset clears the error (async: before any clock edge).
    #2 rst_n = 1'b0;
    #1 chk("reset clears err", {31'd0, err_o}, 32'd0);
    chk("reset clears led", {23'd0, led_o}, 32'd0);

    // Write error via arbitration loss.
    do_reset(1'b0);
    wait_strobe(1'b0, "write strobe arb case");
    finish_xfer(1'b0, 8'h00, 1'b1, 1'b0);
    tick(2);
    chk("wr arb err", {31'd0, err_o}, 32'd1);
    count_strobes(20, ns);
    chk("no read after wr arb", ns, 32'd0);

    // Write error via NACK.
    do_reset(1'b0);
    chk("err cleared before rxak case", {31'd0, err_o}, 32'd0);
    wait_strobe(1'b0, "write strobe rxak case");
    finish_xfer(1'b0, 8'h00, 1'b0, 1'b1);
    tick(2);
    chk("wr rxak err", {31'd0, err_o}, 32'd1);

    // Reset mid-read: outputs drop immediately, then restart from the wake write.
    do_reset(1'b0);
    wait_strobe(1'b0, "write strobe midreset case");
    finish_xfer(1'b0, 8'h00, 1'b0, 1'b0);
    wait_strobe(1'b1, "read strobe midreset case");
    busy = 1'b1;
    tick(1);
    #2 rst_n = 1'b0;
    #1 chk("midreset cmd", {24'd0, cmd_o}, 32'd0);
    chk("midreset addr", {24'd0, addr_o}, 32'd0);
    tick(1);
    busy = 1'b0;
    rst_n = 1'b1;
    tick(1);
    chk("restart cmd", {24'd0, cmd_o}, 32'h6B);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
